// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter for a shared FIFO, granting bursts of up to BURST_LEN beats.
// Define FIFO_ARB_STATS_EN to add saturating per-requester transfer counters (stat0/stat1).
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req0_valid,
  input  logic [2*DATA_WIDTH-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [2*DATA_WIDTH-1:0] req1_data,
  output logic                    req1_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [2*DATA_WIDTH-1:0] fifo_w_data,
  output logic [1:0]              grant
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]             stat0,
  output logic [15:0]             stat1
`endif
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  // Encodings double as the one-hot grant output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t     state, state_nxt, own_state, other_state;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       rr_last, rr_last_nxt;
  logic       own_valid, other_valid, release_grant;

  assign grant = state;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      rr_last  <= 1'b1;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      rr_last  <= rr_last_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    rr_last_nxt   = rr_last;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    fifo_wr       = 1'b0;
    fifo_w_data   = req1_data;
    own_valid     = 1'b0;
    other_valid   = 1'b0;
    own_state     = IDLE;
    other_state   = IDLE;
    release_grant = 1'b0;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nxt = rr_last ? OWN0 : OWN1;
        else if (req0_valid)          state_nxt = OWN0;
        else if (req1_valid)          state_nxt = OWN1;
      end
      OWN0: begin
        req0_ready  = !fifo_full;
        fifo_wr     = req0_valid && !fifo_full;
        fifo_w_data = req0_data;
        own_valid   = req0_valid;
        other_valid = req1_valid;
        own_state   = OWN0;
        other_state = OWN1;
      end
      OWN1: begin
        req1_ready  = !fifo_full;
        fifo_wr     = req1_valid && !fifo_full;
        own_valid   = req1_valid;
        other_valid = req0_valid;
        own_state   = OWN1;
        other_state = OWN0;
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled owner keeps its grant and count; only a dropped valid or the final beat releases it.
    if (state == OWN0 || state == OWN1) begin
      release_grant = !own_valid || (fifo_wr && beat_cnt == LAST_BEAT);
      if (release_grant) begin
        rr_last_nxt  = (state == OWN1);
        beat_cnt_nxt = '0;
        if (other_valid)    state_nxt = other_state;
        else if (own_valid) state_nxt = own_state;
        else                state_nxt = IDLE;
      end else if (fifo_wr) begin
        beat_cnt_nxt = beat_cnt + 4'd1;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat0 <= '0;
      stat1 <= '0;
    end else if (fifo_wr) begin
      if (state == OWN0 && stat0 != 16'hFFFF) stat0 <= stat0 + 16'd1;
      if (state == OWN1 && stat1 != 16'hFFFF) stat1 <= stat1 + 16'd1;
    end
  end
`endif

endmodule
